// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single combinational ALU.
// The result sits in a one-entry output register with valid/ready handshake.
// A new operation is accepted whenever that register is empty or being drained,
// so results stream back-to-back at one per cycle.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [3:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [3:0]        req1_op,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_id,
   output logic              resp_err
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0010,
      OP_AND  = 4'b0100,
      OP_OR   = 4'b0101,
      OP_NOR  = 4'b0110,
      OP_XOR  = 4'b0111,
      OP_SLL  = 4'b1000,
      OP_SRL  = 4'b1001,
      OP_SRLU = 4'b1010
   } alu_op_e;

   logic              last_grant;
   logic              grant;
   logic              can_accept;
   logic              accept;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [3:0]        sel_op;
   logic [DATA_W-1:0] alu_result;
   logic              alu_err;
   logic              shift_oob;

   // Round-robin pick: a lone requester wins outright, on a tie the one that
   // did not win last time gets the slot.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // The output register can take a new result if it is empty or being read
   // this cycle; ready is held low while reset is asserted.
   assign can_accept = !resp_valid || resp_ready;
   assign req0_ready = rst_n && can_accept && (grant == 1'b0) && req0_valid;
   assign req1_ready = rst_n && can_accept && (grant == 1'b1) && req1_valid;
   assign accept     = req0_ready || req1_ready;

   // Operand mux feeding the single shared ALU.
   always_comb begin
      sel_a  = req0_a;
      sel_b  = req0_b;
      sel_op = req0_op;
      if (grant) begin
         sel_a  = req1_a;
         sel_b  = req1_b;
         sel_op = req1_op;
      end
   end

   // Any shift of 32 or more clears the result, so the upper bits of b matter.
   assign shift_oob = |sel_b[DATA_W-1:5];

   // Combinational ALU; unknown op codes produce zero with the error flag set.
   always_comb begin
      alu_result = '0;
      alu_err    = 1'b0;
      case (sel_op)
         OP_ADD:  alu_result = sel_a + sel_b;
         OP_SUB:  alu_result = sel_a - sel_b;
         OP_AND:  alu_result = sel_a & sel_b;
         OP_OR:   alu_result = sel_a | sel_b;
         OP_NOR:  alu_result = ~(sel_a | sel_b);
         OP_XOR:  alu_result = sel_a ^ sel_b;
         OP_SLL:  alu_result = shift_oob ? '0 : (sel_a << sel_b[4:0]);
         OP_SRL:  alu_result = shift_oob ? '0 : (sel_a >> sel_b[4:0]);
         OP_SRLU: alu_result = shift_oob ? '0 : (sel_a >> sel_b[4:0]);
         default: begin
            alu_result = '0;
            alu_err    = 1'b1;
         end
      endcase
   end

   // Result register and arbitration history; last_grant moves only when an
   // operation is actually taken, and the payload holds while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= 1'b0;
         resp_err   <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_data  <= alu_result;
         resp_id    <= grant;
         resp_err   <= alu_err;
         last_grant <= grant;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset values, single ops, op table corners,
// round-robin alternation, output stall, idle-cycle fairness and async reset.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_op;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_op;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_id;
   logic        resp_err;

   int total;
   int bad;

   alu_arbiter #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_err   (resp_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Drive both request ports and the response ready in one go.
   task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic rr);
      req0_valid = v0;
      req0_op    = op0;
      req0_a     = a0;
      req0_b     = b0;
      req1_valid = v1;
      req1_op    = op1;
      req1_a     = a1;
      req1_b     = b1;
      resp_ready = rr;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse released away from the clock edge.
   task automatic doReset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[14];

   initial begin
      total = 0;
      bad   = 0;

      vecs[0]  = '{4'b0010, 32'h0000_0000, 32'd1,         32'hFFFF_FFFF, 1'b0};
      vecs[1]  = '{4'b1010, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0};
      vecs[2]  = '{4'b1000, 32'h0000_0001, 32'd32,        32'h0000_0000, 1'b0};
      vecs[3]  = '{4'b0011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b1};
      vecs[4]  = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[5]  = '{4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0};
      vecs[6]  = '{4'b0101, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0, 1'b0};
      vecs[7]  = '{4'b0110, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[8]  = '{4'b0111, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0};
      vecs[9]  = '{4'b1001, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0};
      vecs[10] = '{4'b1000, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0};
      vecs[11] = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0};
      vecs[12] = '{4'b1001, 32'hFFFF_FFFF, 32'd33,        32'h0000_0000, 1'b0};
      vecs[13] = '{4'b1010, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0};

      // Reset state with both requesters asserting valid
      rst_n = 1'b0;
      applyStimulus(1'b1, 4'b0000, 32'd1, 32'd1, 1'b1, 4'b0000, 32'd2, 32'd2, 1'b1);
      #3;
      checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("rst_resp_data", resp_data, 32'd0);
      checkOutput("rst_resp_id", {31'b0, resp_id}, 32'd0);
      checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
      checkOutput("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      checkOutput("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
      step();
      step();
      checkOutput("rst_hold_valid", {31'b0, resp_valid}, 32'd0);

      // Basic add from requester 0, accepted on first edge after release
      applyStimulus(1'b1, 4'b0000, 32'd5, 32'd7, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
      rst_n = 1'b1;
      #1;
      checkOutput("add_req0_ready", {31'b0, req0_ready}, 32'd1);
      step();
      req0_valid = 1'b0;
      checkOutput("add_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("add_data", resp_data, 32'd12);
      checkOutput("add_id", {31'b0, resp_id}, 32'd0);
      checkOutput("add_err", {31'b0, resp_err}, 32'd0);
      step();
      checkOutput("add_drain_valid", {31'b0, resp_valid}, 32'd0);

      // Op table corners through requester 1
      foreach (vecs[i]) begin
         applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
         #1;
         checkOutput($sformatf("op%0d_ready", i), {31'b0, req1_ready}, 32'd1);
         step();
         req1_valid = 1'b0;
         checkOutput($sformatf("op%0d_data", i), resp_data, vecs[i].exp);
         checkOutput($sformatf("op%0d_err", i), {31'b0, resp_err}, {31'b0, vecs[i].err});
         checkOutput($sformatf("op%0d_id", i), {31'b0, resp_id}, 32'd1);
         step();
         checkOutput($sformatf("op%0d_clear", i), {31'b0, resp_valid}, 32'd0);
      end

      // Round-robin with both valid every cycle, starting fresh from reset
      applyStimulus(1'b0, 4'b0000, 32'd0, 32'd0, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b1);
      doReset();
      applyStimulus(1'b1, 4'b0000, 32'd1, 32'd2, 1'b1, 4'b0111, 32'hF0, 32'h0F, 1'b1);
      #1;
      checkOutput("rr_first_ready0", {31'b0, req0_ready}, 32'd1);
      checkOutput("rr_first_ready1", {31'b0, req1_ready}, 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         checkOutput($sformatf("rr%0d_valid", i), {31'b0, resp_valid}, 32'd1);
         checkOutput($sformatf("rr%0d_id", i), {31'b0, resp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("rr%0d_data", i), resp_data, (i % 2 == 1) ? 32'hFF : 32'd3);
         checkOutput($sformatf("rr%0d_next_ready0", i), {31'b0, req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      end

      // Output stall: result from requester 1 must hold, nobody accepted
      resp_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("stall%0d_ready0", i), {31'b0, req0_ready}, 32'd0);
         checkOutput($sformatf("stall%0d_ready1", i), {31'b0, req1_ready}, 32'd0);
         checkOutput($sformatf("stall%0d_data", i), resp_data, 32'hFF);
         checkOutput($sformatf("stall%0d_id", i), {31'b0, resp_id}, 32'd1);
         checkOutput($sformatf("stall%0d_valid", i), {31'b0, resp_valid}, 32'd1);
         step();
      end
      resp_ready = 1'b1;
      #1;
      checkOutput("unstall_ready0", {31'b0, req0_ready}, 32'd1);
      step();
      checkOutput("unstall_id", {31'b0, resp_id}, 32'd0);
      checkOutput("unstall_data", resp_data, 32'd3);

      // Idle cycle must not disturb last_grant: requester 1 wins the next tie
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step();
      checkOutput("idle_valid", {31'b0, resp_valid}, 32'd0);
      step();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checkOutput("idle_tie_ready1", {31'b0, req1_ready}, 32'd1);
      checkOutput("idle_tie_ready0", {31'b0, req0_ready}, 32'd0);
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("idle_tie_id", {31'b0, resp_id}, 32'd1);
      step();

      // Asynchronous reset while a result is stalled discards it
      applyStimulus(1'b1, 4'b0000, 32'd5, 32'd7, 1'b0, 4'b0000, 32'd0, 32'd0, 1'b0);
      step();
      req0_valid = 1'b0;
      step();
      checkOutput("hold_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("hold_data", resp_data, 32'd12);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("async_rst_data", resp_data, 32'd0);
      resp_ready = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      checkOutput("post_rst_valid0", {31'b0, resp_valid}, 32'd0);
      step();
      checkOutput("post_rst_valid1", {31'b0, resp_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  32 each  requester 0 operands.
REQ-007 Port: req0_op  input  4  requester 0 ALU operation code.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions/widths as requester 0.
REQ-009 Port: resp_valid  output  1  result register holds a result.
REQ-010 Port: resp_ready  input  1  consumer takes result this cycle.
REQ-011 Port: resp_data  output  32  registered ALU result.
REQ-012 Port: resp_id  output  1  index of requester that issued the result.
REQ-013 Port: resp_err  output  1  result came from an illegal op code.

Function
REQ-014 Transfer on a request port SHALL occur when reqN_valid && reqN_ready in the same cycle; the same rule applies to resp_valid && resp_ready.
REQ-015 Block SHALL contain one ALU instance (combinational) and a single-entry result register; no other buffering.
REQ-016 can_accept SHALL be !resp_valid || resp_ready; reqN_ready SHALL be can_accept && grant==N && reqN_valid, so at most one ready is high per cycle.
REQ-017 Arbitration SHALL be round-robin: only one valid -> that one granted; both valid -> the requester not in last_grant granted.
REQ-018 last_grant SHALL update only on an accepted request transfer; stalls and idle cycles leave it unchanged.
REQ-019 Latency SHALL be one cycle: operation accepted in cycle T appears with resp_valid=1 in cycle T+1.
REQ-020 Simultaneous resp transfer and new accept SHALL give back-to-back results with no bubble (throughput one per cycle).
REQ-021 resp_valid SHALL clear after a response transfer with no new accept in the same cycle.
REQ-022 resp_data/id/err SHALL hold stable while resp_valid && !resp_ready.
REQ-023 Op table SHALL be: 0000 a+b; 0010 a-b; 0100 a&b; 0101 a|b; 0110 ~(a|b); 0111 a^b; 1000 a<<b; 1001 a>>b; 1010 a>>b logical (operands unsigned); all arithmetic modulo 2^32, carries dropped.
REQ-024 Shift amount SHALL be the full 32-bit b; b>=32 yields 0 for ops 1000/1001/1010.
REQ-025 Any other op code SHALL yield resp_data=0 and resp_err=1; legal codes give resp_err=0.
REQ-026 Requesters SHALL hold valid and operands stable until ready; arbiter behaviour is undefined if valid drops early.
REQ-027 Round-robin SHALL bound wait: a continuously valid requester is accepted within two accepts of the other requester.

Reset
REQ-028 rst_n low SHALL immediately force resp_valid=0, resp_data=0, resp_id=0, resp_err=0, last_grant=1 (requester 0 wins first tie).
REQ-029 Reset mid-operation SHALL discard the held result; no response is emitted for it after release.
REQ-030 req0_ready and req1_ready SHALL be 0 while rst_n is low.
REQ-031 First rising edge after rst_n release SHALL be able to accept a request.

Verification
REQ-032 req0 only, op=0000, a=5, b=7, resp_ready=1 -> next cycle resp_valid=1, data=12, id=0, err=0.
REQ-033 Both valid every cycle, resp_ready=1 -> accepts alternate 0,1,0,1 starting with 0 after reset; no idle cycles.
REQ-034 resp_ready=0 for 3 cycles with result held -> both ready=0, resp_data unchanged; on resp_ready=1 next result follows in the following cycle.
REQ-035 op=0010, a=0, b=1 -> data=0xFFFFFFFF; op=1010, a=0x80000000, b=4 -> 0x08000000; op=1000, b=32 -> 0.
REQ-036 op=0011 -> data=0, err=1; op=1111 -> data=0, err=1.
REQ-037 rst_n pulsed low while resp_valid=1 and resp_ready=0 -> resp_valid=0 immediately (asynchronously); held result never delivered.
